// File: rtl/axi_bridge_pkg.sv
// Shared response codes, FSM state encodings and helpers for the AXI4-Lite CDC bridge.
package axi_bridge_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {W_IDLE, W_REQ, W_REL, W_RESP} w_state_t;
   typedef enum logic [1:0] {R_IDLE, R_REQ, R_REL, R_RESP} r_state_t;

   // Saturating add of up to two error events onto an 8-bit counter.
   function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] b);
      logic [8:0] s;
      s = {1'b0, a} + 9'(b);
      return s[8] ? 8'hFF : s[7:0];
   endfunction

endpackage

// File: rtl/ack_sync.sv
// Per-bit flop chain bringing foreign-domain ack levels into the AXI clock domain.
module ack_sync #(
   parameter int unsigned WIDTH  = 1,
   parameter int unsigned STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [STAGES-1:0][WIDTH-1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= '0;
      else        sync_q <= {sync_q[STAGES-2:0], d};
   end

   assign q = sync_q[STAGES-1];

endmodule

// File: rtl/axi_lite_cdc_bridge.sv
// AXI4-Lite slave forwarding single-beat accesses to N_CH core register ports via
// four-phase req/ack handshakes with synchronised acks, timeout, decode errors and irq.
module axi_lite_cdc_bridge
   import axi_bridge_pkg::*;
#(
   parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
   parameter int unsigned C_S_AXI_ADDR_WIDTH = 8,
   parameter int unsigned N_CH               = 2,
   parameter int unsigned SYNC_STAGES        = 2,
   parameter int unsigned TIMEOUT_CYC        = 1023
) (
   input  logic                               s_axi_aclk,
   input  logic                               s_axi_aresetn,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]      s_axi_awaddr,
   input  logic                               s_axi_awvalid,
   output logic                               s_axi_awready,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]      s_axi_wdata,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]    s_axi_wstrb,
   input  logic                               s_axi_wvalid,
   output logic                               s_axi_wready,
   output logic [1:0]                         s_axi_bresp,
   output logic                               s_axi_bvalid,
   input  logic                               s_axi_bready,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]      s_axi_araddr,
   input  logic                               s_axi_arvalid,
   output logic                               s_axi_arready,
   output logic [C_S_AXI_DATA_WIDTH-1:0]      s_axi_rdata,
   output logic [1:0]                         s_axi_rresp,
   output logic                               s_axi_rvalid,
   input  logic                               s_axi_rready,
   output logic                               irq,
   input  logic                               irq_clr,
   output logic [7:0]                         err_cnt,
   output logic [C_S_AXI_ADDR_WIDTH-1:0]      core_wr_addr,
   output logic [C_S_AXI_DATA_WIDTH-1:0]      core_wr_data,
   output logic [C_S_AXI_DATA_WIDTH/8-1:0]    core_wr_strb,
   output logic [N_CH-1:0]                    core_wr_req,
   input  logic [N_CH-1:0]                    core_wr_ack,
   output logic [C_S_AXI_ADDR_WIDTH-1:0]      core_rd_addr,
   output logic [N_CH-1:0]                    core_rd_req,
   input  logic [N_CH-1:0]                    core_rd_ack,
   input  logic [N_CH*C_S_AXI_DATA_WIDTH-1:0] core_rd_data
);

   localparam int unsigned DATA_W = C_S_AXI_DATA_WIDTH;
   localparam int unsigned ADDR_W = C_S_AXI_ADDR_WIDTH;
   localparam int unsigned STRB_W = DATA_W / 8;
   localparam int unsigned CH_W   = (N_CH < 2) ? 1 : $clog2(N_CH);
   localparam int unsigned TMO_W  = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
   localparam bit          TMO_EN = (TIMEOUT_CYC != 0);
   localparam logic [CH_W:0]    N_CH_V   = (CH_W+1)'(N_CH);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_EN ? TIMEOUT_CYC - 32'd1 : 32'd0);

   function automatic logic ch_bad(input logic [CH_W-1:0] ch);
      return {1'b0, ch} >= N_CH_V;
   endfunction

   logic [N_CH-1:0] wr_ack_s, rd_ack_s;

   ack_sync #(.WIDTH(N_CH), .STAGES(SYNC_STAGES)) u_wr_sync (
      .clk(s_axi_aclk), .rst_n(s_axi_aresetn), .d(core_wr_ack), .q(wr_ack_s));
   ack_sync #(.WIDTH(N_CH), .STAGES(SYNC_STAGES)) u_rd_sync (
      .clk(s_axi_aclk), .rst_n(s_axi_aresetn), .d(core_rd_ack), .q(rd_ack_s));

   // ---------------- write path ----------------
   w_state_t            w_state_q, w_state_d;
   logic                aw_got_q, aw_got_d, w_got_q, w_got_d;
   logic                awready_q, awready_d, wready_q, wready_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0]   wr_data_q, wr_data_d;
   logic [STRB_W-1:0]   wr_strb_q, wr_strb_d;
   logic [CH_W-1:0]     wr_ch_q, wr_ch_d;
   logic [N_CH-1:0]     wr_req_q, wr_req_d;
   logic                bvalid_q, bvalid_d;
   logic [1:0]          bresp_q, bresp_d;
   logic [TMO_W-1:0]    wr_tmo_q, wr_tmo_d;
   logic                wr_err, wr_ack_sel, aw_hs, w_hs;

   assign aw_hs = s_axi_awvalid & awready_q;
   assign w_hs  = s_axi_wvalid & wready_q;

   always_comb begin
      wr_ack_sel = 1'b0;
      for (int i = 0; i < N_CH; i++)
         if (wr_ch_q == CH_W'(i)) wr_ack_sel = wr_ack_s[i];
   end

   always_comb begin
      w_state_d = w_state_q;
      aw_got_d  = aw_got_q;
      w_got_d   = w_got_q;
      awready_d = awready_q;
      wready_d  = wready_q;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      wr_strb_d = wr_strb_q;
      wr_ch_d   = wr_ch_q;
      wr_req_d  = wr_req_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      wr_tmo_d  = wr_tmo_q;
      wr_err    = 1'b0;
      case (w_state_q)
         W_IDLE: begin
            awready_d = 1'b1;
            wready_d  = 1'b1;
            if (aw_got_q) awready_d = 1'b0;
            if (w_got_q)  wready_d  = 1'b0;
            if (aw_hs) begin
               wr_addr_d = s_axi_awaddr;
               aw_got_d  = 1'b1;
               awready_d = 1'b0;
            end
            if (w_hs) begin
               wr_data_d = s_axi_wdata;
               wr_strb_d = s_axi_wstrb;
               w_got_d   = 1'b1;
               wready_d  = 1'b0;
            end
            if ((aw_got_q | aw_hs) && (w_got_q | w_hs)) begin
               aw_got_d = 1'b0;
               w_got_d  = 1'b0;
               wr_tmo_d = '0;
               wr_ch_d  = wr_addr_d[ADDR_W-1 -: CH_W];
               if (ch_bad(wr_ch_d)) begin
                  bvalid_d  = 1'b1;
                  bresp_d   = RESP_DECERR;
                  wr_err    = 1'b1;
                  w_state_d = W_RESP;
               end else begin
                  w_state_d = W_REQ;
               end
            end
         end
         // Req is only raised once the synced ack is seen low, so a late ack from an aborted
         // transfer can never complete this one.
         W_REQ: begin
            wr_tmo_d = wr_tmo_q + TMO_W'(1);
            if ((|wr_req_q) && wr_ack_sel) begin
               wr_req_d  = '0;
               w_state_d = W_REL;
            end else if (TMO_EN && wr_tmo_q == TMO_LAST) begin
               wr_req_d  = '0;
               bvalid_d  = 1'b1;
               bresp_d   = RESP_SLVERR;
               wr_err    = 1'b1;
               w_state_d = W_RESP;
            end else if (!(|wr_req_q) && !wr_ack_sel) begin
               wr_req_d = N_CH'(1) << wr_ch_q;
            end
         end
         W_REL: begin
            wr_tmo_d = wr_tmo_q + TMO_W'(1);
            if (!wr_ack_sel) begin
               bvalid_d  = 1'b1;
               bresp_d   = RESP_OKAY;
               w_state_d = W_RESP;
            end else if (TMO_EN && wr_tmo_q == TMO_LAST) begin
               bvalid_d  = 1'b1;
               bresp_d   = RESP_SLVERR;
               wr_err    = 1'b1;
               w_state_d = W_RESP;
            end
         end
         W_RESP: begin
            if (s_axi_bready) begin
               bvalid_d  = 1'b0;
               awready_d = 1'b1;
               wready_d  = 1'b1;
               w_state_d = W_IDLE;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         w_state_q <= W_IDLE;
         aw_got_q  <= 1'b0;
         w_got_q   <= 1'b0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         wr_strb_q <= '0;
         wr_ch_q   <= '0;
         wr_req_q  <= '0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
         wr_tmo_q  <= '0;
      end else begin
         w_state_q <= w_state_d;
         aw_got_q  <= aw_got_d;
         w_got_q   <= w_got_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         wr_strb_q <= wr_strb_d;
         wr_ch_q   <= wr_ch_d;
         wr_req_q  <= wr_req_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
         wr_tmo_q  <= wr_tmo_d;
      end
   end

   // ---------------- read path ----------------
   r_state_t            r_state_q, r_state_d;
   logic                arready_q, arready_d;
   logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
   logic [CH_W-1:0]     rd_ch_q, rd_ch_d;
   logic [N_CH-1:0]     rd_req_q, rd_req_d;
   logic                rvalid_q, rvalid_d;
   logic [1:0]          rresp_q, rresp_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d, rd_sel;
   logic [TMO_W-1:0]    rd_tmo_q, rd_tmo_d;
   logic                rd_err, rd_ack_sel;

   always_comb begin
      rd_ack_sel = 1'b0;
      rd_sel     = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (rd_ch_q == CH_W'(i)) begin
            rd_ack_sel = rd_ack_s[i];
            rd_sel     = core_rd_data[i*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      r_state_d = r_state_q;
      arready_d = arready_q;
      rd_addr_d = rd_addr_q;
      rd_ch_d   = rd_ch_q;
      rd_req_d  = rd_req_q;
      rvalid_d  = rvalid_q;
      rresp_d   = rresp_q;
      rdata_d   = rdata_q;
      rd_tmo_d  = rd_tmo_q;
      rd_err    = 1'b0;
      case (r_state_q)
         R_IDLE: begin
            arready_d = 1'b1;
            if (s_axi_arvalid && arready_q) begin
               rd_addr_d = s_axi_araddr;
               rd_ch_d   = s_axi_araddr[ADDR_W-1 -: CH_W];
               arready_d = 1'b0;
               rd_tmo_d  = '0;
               if (ch_bad(rd_ch_d)) begin
                  rvalid_d  = 1'b1;
                  rresp_d   = RESP_DECERR;
                  rdata_d   = '0;
                  rd_err    = 1'b1;
                  r_state_d = R_RESP;
               end else begin
                  r_state_d = R_REQ;
               end
            end
         end
         R_REQ: begin
            rd_tmo_d = rd_tmo_q + TMO_W'(1);
            if ((|rd_req_q) && rd_ack_sel) begin
               rdata_d   = rd_sel;
               rd_req_d  = '0;
               r_state_d = R_REL;
            end else if (TMO_EN && rd_tmo_q == TMO_LAST) begin
               rd_req_d  = '0;
               rvalid_d  = 1'b1;
               rresp_d   = RESP_SLVERR;
               rdata_d   = '0;
               rd_err    = 1'b1;
               r_state_d = R_RESP;
            end else if (!(|rd_req_q) && !rd_ack_sel) begin
               rd_req_d = N_CH'(1) << rd_ch_q;
            end
         end
         R_REL: begin
            rd_tmo_d = rd_tmo_q + TMO_W'(1);
            if (!rd_ack_sel) begin
               rvalid_d  = 1'b1;
               rresp_d   = RESP_OKAY;
               r_state_d = R_RESP;
            end else if (TMO_EN && rd_tmo_q == TMO_LAST) begin
               rvalid_d  = 1'b1;
               rresp_d   = RESP_SLVERR;
               rdata_d   = '0;
               rd_err    = 1'b1;
               r_state_d = R_RESP;
            end
         end
         R_RESP: begin
            if (s_axi_rready) begin
               rvalid_d  = 1'b0;
               arready_d = 1'b1;
               r_state_d = R_IDLE;
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         r_state_q <= R_IDLE;
         arready_q <= 1'b0;
         rd_addr_q <= '0;
         rd_ch_q   <= '0;
         rd_req_q  <= '0;
         rvalid_q  <= 1'b0;
         rresp_q   <= RESP_OKAY;
         rdata_q   <= '0;
         rd_tmo_q  <= '0;
      end else begin
         r_state_q <= r_state_d;
         arready_q <= arready_d;
         rd_addr_q <= rd_addr_d;
         rd_ch_q   <= rd_ch_d;
         rd_req_q  <= rd_req_d;
         rvalid_q  <= rvalid_d;
         rresp_q   <= rresp_d;
         rdata_q   <= rdata_d;
         rd_tmo_q  <= rd_tmo_d;
      end
   end

   // ---------------- error counter and sticky irq ----------------
   logic       irq_q, irq_d;
   logic [7:0] err_cnt_q, err_cnt_d;

   always_comb begin
      err_cnt_d = sat_add8(err_cnt_q, 2'(wr_err) + 2'(rd_err));
      irq_d     = (irq_q & ~irq_clr) | wr_err | rd_err;
   end

   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         irq_q     <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         irq_q     <= irq_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign s_axi_awready = awready_q;
   assign s_axi_wready  = wready_q;
   assign s_axi_bvalid  = bvalid_q;
   assign s_axi_bresp   = bresp_q;
   assign s_axi_arready = arready_q;
   assign s_axi_rvalid  = rvalid_q;
   assign s_axi_rresp   = rresp_q;
   assign s_axi_rdata   = rdata_q;
   assign core_wr_addr  = wr_addr_q;
   assign core_wr_data  = wr_data_q;
   assign core_wr_strb  = wr_strb_q;
   assign core_wr_req   = wr_req_q;
   assign core_rd_addr  = rd_addr_q;
   assign core_rd_req   = rd_req_q;
   assign irq           = irq_q;
   assign err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_axi_lite_cdc_bridge.sv
// Directed bench for axi_lite_cdc_bridge: 3 channels, 16-cycle timeout, echo-style core acks.
module tb_axi_lite_cdc_bridge;

   localparam int unsigned DW  = 32;
   localparam int unsigned AW  = 8;
   localparam int unsigned NCH = 3;

   logic            clk = 1'b0;
   logic            aresetn;
   logic [AW-1:0]   s_axi_awaddr, s_axi_araddr;
   logic            s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
   logic [DW-1:0]   s_axi_wdata, s_axi_rdata;
   logic [DW/8-1:0] s_axi_wstrb;
   logic [1:0]      s_axi_bresp, s_axi_rresp;
   logic            s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
   logic            s_axi_rvalid, s_axi_rready;
   logic            irq, irq_clr;
   logic [7:0]      err_cnt;
   logic [AW-1:0]   core_wr_addr, core_rd_addr;
   logic [DW-1:0]   core_wr_data;
   logic [DW/8-1:0] core_wr_strb;
   logic [NCH-1:0]  core_wr_req, core_wr_ack, core_rd_req, core_rd_ack;
   logic [NCH*DW-1:0] core_rd_data;
   logic [NCH-1:0]  wr_echo, rd_echo, wr_force;

   int n_cmp = 0;
   int n_mis = 0;

   always #5 clk = ~clk;

   // Core model: acks echo requests when enabled; wr_force injects a late/stale ack.
   assign core_wr_ack  = (core_wr_req & wr_echo) | wr_force;
   assign core_rd_ack  = core_rd_req & rd_echo;
   assign core_rd_data = {32'hCAFEF00D, 32'h12345678, 32'hA0A0A0A0};

   axi_lite_cdc_bridge #(
      .C_S_AXI_DATA_WIDTH(DW), .C_S_AXI_ADDR_WIDTH(AW), .N_CH(NCH),
      .SYNC_STAGES(2), .TIMEOUT_CYC(16)
   ) dut (
      .s_axi_aclk(clk), .s_axi_aresetn(aresetn),
      .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
      .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
      .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
      .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
      .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
      .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
      .irq(irq), .irq_clr(irq_clr), .err_cnt(err_cnt),
      .core_wr_addr(core_wr_addr), .core_wr_data(core_wr_data), .core_wr_strb(core_wr_strb),
      .core_wr_req(core_wr_req), .core_wr_ack(core_wr_ack),
      .core_rd_addr(core_rd_addr), .core_rd_req(core_rd_req), .core_rd_ack(core_rd_ack),
      .core_rd_data(core_rd_data)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_txn(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                         input logic [3:0] strb, input int aw_dly, input int w_dly,
                         output logic [1:0] resp, output logic [NCH-1:0] seen,
                         output logic [DW-1:0] cd, output logic [3:0] cs, output int lat);
      bit aw_done = 0, w_done = 0, got = 0;
      int c = 0;
      resp = 2'b01; seen = '0; cd = '0; cs = '0;
      s_axi_bready = 1'b1;
      while (!got && c < 200) begin
         s_axi_awaddr  = addr;
         s_axi_wdata   = data;
         s_axi_wstrb   = strb;
         s_axi_awvalid = !aw_done && (c >= aw_dly);
         s_axi_wvalid  = !w_done && (c >= w_dly);
         if (s_axi_awvalid && s_axi_awready) aw_done = 1;
         if (s_axi_wvalid && s_axi_wready)   w_done = 1;
         if (core_wr_req != '0) begin
            seen |= core_wr_req;
            cd = core_wr_data;
            cs = core_wr_strb;
         end
         if (s_axi_bvalid) begin
            resp = s_axi_bresp;
            got  = 1;
         end
         step();
         c++;
      end
      s_axi_awvalid = 1'b0;
      s_axi_wvalid  = 1'b0;
      lat = c;
      chk("wr_completed", 32'(got), 32'd1);
   endtask

   task automatic rd_txn(input logic [AW-1:0] addr, input int rdy_dly,
                         output logic [1:0] resp, output logic [DW-1:0] rd,
                         output logic [NCH-1:0] seen, output bit stable);
      bit ar_done = 0, got = 0;
      int c = 0, held = 0;
      resp = 2'b01; rd = '0; seen = '0; stable = 1;
      s_axi_rready = 1'b0;
      while (!got && c < 200) begin
         s_axi_araddr  = addr;
         s_axi_arvalid = !ar_done;
         if (s_axi_arvalid && s_axi_arready) ar_done = 1;
         if (core_rd_req != '0) seen |= core_rd_req;
         if (s_axi_rvalid) begin
            if (held == 0) begin
               rd   = s_axi_rdata;
               resp = s_axi_rresp;
            end else if (s_axi_rdata !== rd || s_axi_rresp !== resp) begin
               stable = 0;
            end
            if (held >= rdy_dly) begin
               s_axi_rready = 1'b1;
               got = 1;
            end
            held++;
         end
         step();
         c++;
      end
      s_axi_rready  = 1'b0;
      s_axi_arvalid = 1'b0;
      chk("rd_completed", 32'(got), 32'd1);
   endtask

   logic [1:0]     resp;
   logic [NCH-1:0] seen;
   logic [DW-1:0]  cd;
   logic [3:0]     cs;
   int             lat;
   bit             stable, ok;

   initial begin
      aresetn = 1'b0;
      s_axi_awaddr = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
      s_axi_wvalid = 1'b0; s_axi_bready = 1'b0; s_axi_araddr = '0; s_axi_arvalid = 1'b0;
      s_axi_rready = 1'b0; irq_clr = 1'b0;
      wr_echo = '1; rd_echo = '1; wr_force = '0;

      // Reset state
      repeat (2) step();
      chk("rst_awready", 32'(s_axi_awready), 32'd0);
      chk("rst_arready", 32'(s_axi_arready), 32'd0);
      chk("rst_bvalid",  32'(s_axi_bvalid),  32'd0);
      chk("rst_rvalid",  32'(s_axi_rvalid),  32'd0);
      chk("rst_rdata",   s_axi_rdata,        32'd0);
      chk("rst_irq_cnt", {23'd0, irq, err_cnt}, 32'd0);
      chk("rst_wr_req",  32'(core_wr_req),   32'd0);
      aresetn = 1'b1;
      repeat (2) step();
      chk("post_rst_readies", {29'd0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'd7);

      // 1: AW then W three cycles later, ch0
      wr_txn(8'h04, 32'hDEADBEEF, 4'hF, 0, 3, resp, seen, cd, cs, lat);
      chk("t1_bresp", 32'(resp), 32'd0);
      chk("t1_req",   32'(seen), 32'b001);
      chk("t1_data",  cd,        32'hDEADBEEF);
      chk("t1_strb",  32'(cs),   32'hF);
      chk("t1_addr",  32'(core_wr_addr), 32'h04);
      chk("t1_irq",   32'(irq),  32'd0);

      // 2: W before AW, then both same cycle, ch1
      wr_txn(8'h44, 32'h0000BEEF, 4'h3, 2, 0, resp, seen, cd, cs, lat);
      chk("t2a_bresp", 32'(resp), 32'd0);
      chk("t2a_req",   32'(seen), 32'b010);
      chk("t2a_strb",  32'(cs),   32'h3);
      wr_txn(8'h48, 32'h11223344, 4'hC, 0, 0, resp, seen, cd, cs, lat);
      chk("t2b_bresp", 32'(resp), 32'd0);
      chk("t2b_req",   32'(seen), 32'b010);
      chk("t2b_data",  cd,        32'h11223344);
      chk("t2b_strb",  32'(cs),   32'hC);

      // 3: read ch1 with rready held off for 10 cycles
      rd_txn(8'h40, 10, resp, cd, seen, stable);
      chk("t3_rresp",  32'(resp),   32'd0);
      chk("t3_rdata",  cd,          32'h12345678);
      chk("t3_req",    32'(seen),   32'b010);
      chk("t3_stable", 32'(stable), 32'd1);
      chk("t3_rvalid_drop", 32'(s_axi_rvalid), 32'd0);

      // 4: ch0 never acks -> timeout SLVERR
      wr_echo = 3'b110;
      wr_txn(8'h08, 32'hA5A5A5A5, 4'hF, 0, 0, resp, seen, cd, cs, lat);
      chk("t4_bresp",   32'(resp), 32'd2);
      chk("t4_req",     32'(seen), 32'b001);
      chk("t4_req_off", 32'(core_wr_req), 32'd0);
      chk("t4_lat_ge16", 32'(lat >= 16), 32'd1);
      chk("t4_irq",     32'(irq), 32'd1);
      chk("t4_errcnt",  32'(err_cnt), 32'd1);

      // Late ack arrives; next write must hold req until the synced ack is low
      wr_force = 3'b001;
      wr_echo  = 3'b111;
      repeat (4) step();
      s_axi_awaddr = 8'h0C; s_axi_wdata = 32'h5A5A5A5A; s_axi_wstrb = 4'hF;
      s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_bready = 1'b1;
      chk("t4_readies", {30'd0, s_axi_awready, s_axi_wready}, 32'd3);
      step();
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
      ok = 1;
      repeat (3) begin
         if (core_wr_req != '0) ok = 0;
         step();
      end
      chk("t4_stale_guard", 32'(ok), 32'd1);
      wr_force = '0;
      seen = '0; ok = 0;
      for (int i = 0; i < 50 && !ok; i++) begin
         seen |= core_wr_req;
         if (s_axi_bvalid) begin
            ok = 1;
            resp = s_axi_bresp;
         end
         step();
      end
      chk("t4b_done",  32'(ok),   32'd1);
      chk("t4b_bresp", 32'(resp), 32'd0);
      chk("t4b_req",   32'(seen), 32'b001);
      chk("t4b_irq_sticky", 32'(irq), 32'd1);
      irq_clr = 1'b1;
      step();
      irq_clr = 1'b0;
      chk("t4_irq_clr", 32'(irq), 32'd0);
      chk("t4_errcnt_hold", 32'(err_cnt), 32'd1);

      // 5: channel 3 does not exist -> DECERR, no req, rdata cleared
      rd_txn(8'hC0, 0, resp, cd, seen, stable);
      chk("t5_rresp",  32'(resp), 32'd3);
      chk("t5_rdata",  cd,        32'd0);
      chk("t5_rd_req", 32'(seen), 32'd0);
      chk("t5_errcnt_rd", 32'(err_cnt), 32'd2);
      wr_txn(8'hC4, 32'h01020304, 4'hF, 0, 0, resp, seen, cd, cs, lat);
      chk("t5_bresp",  32'(resp), 32'd3);
      chk("t5_wr_req", 32'(seen), 32'd0);
      chk("t5_errcnt_wr", 32'(err_cnt), 32'd3);
      chk("t5_irq",    32'(irq),  32'd1);

      // 6: reset asserted while a write request is outstanding
      wr_echo = 3'b110;
      s_axi_awaddr = 8'h10; s_axi_wdata = 32'h77777777; s_axi_wstrb = 4'hF;
      s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
      step();
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
      ok = 0;
      for (int i = 0; i < 10 && !ok; i++) begin
         if (core_wr_req[0]) ok = 1;
         else step();
      end
      chk("t6_req_up", 32'(ok), 32'd1);
      aresetn = 1'b0;
      #1;
      chk("t6_req_drop",  32'(core_wr_req),  32'd0);
      chk("t6_bvalid",    32'(s_axi_bvalid), 32'd0);
      step();
      chk("t6_awready_rst", 32'(s_axi_awready), 32'd0);
      step();
      aresetn = 1'b1;
      wr_echo = 3'b111;
      repeat (2) step();
      chk("t6_errcnt_rst", 32'(err_cnt), 32'd0);
      wr_txn(8'h14, 32'h0BADF00D, 4'hF, 0, 0, resp, seen, cd, cs, lat);
      chk("t6_bresp", 32'(resp), 32'd0);
      chk("t6_req",   32'(seen), 32'b001);
      chk("t6_data",  cd,        32'h0BADF00D);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
